// File: rtl/uart_rx.sv
// UART receiver: 1 start, WIDTH data bits LSB first, 1 stop, no parity, DIVISOR clocks per bit.
// Define UART_RX_MAJORITY_EN to use a 2-of-3 vote of the synchronized line at each decision edge.
module uart_rx #(
  parameter int WIDTH   = 8,
  parameter int DIVISOR = 100
) (
  input  logic             clk,
  input  logic             i_reset,
  input  logic             i_rx,
  output logic [WIDTH-1:0] o_data,
  output logic             o_dv,
  output logic             o_frame_err,
  output logic             o_busy
);

  localparam int H     = DIVISOR / 2;
  localparam int CNT_W = $clog2(DIVISOR);
  localparam int IDX_W = $clog2(WIDTH) + 1;

  localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(H - 1);
  localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(DIVISOR - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       sync_q;
  logic             rx_s;
  logic             s;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             dv_q, dv_d;
  logic             ferr_q, ferr_d;
  logic [WIDTH:0]   shift_w;

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], i_rx};
    end
  end

  assign rx_s = sync_q[1];

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist_q;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  always_ff @(posedge clk) begin
    if (i_reset) begin
      hist_q <= 2'b11;
    end else begin
      hist_q <= {hist_q[0], rx_s};
    end
  end

  assign s = maj3(rx_s, hist_q[0], hist_q[1]);
`else
  assign s = rx_s;
`endif

  always_ff @(posedge clk) begin
    if (i_reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
      data_q    <= '0;
      dv_q      <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
      data_q    <= data_d;
      dv_q      <= dv_d;
      ferr_q    <= ferr_d;
    end
  end

  // New bit enters at the MSB so bit 0, received first, ends in shreg[0].
  assign shift_w = {s, shreg_q};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    data_d    = data_q;
    dv_d      = 1'b0;
    ferr_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx_s) begin
          state_d = S_START;
        end
      end

      S_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          if (!s) begin
            state_d   = S_DATA;
            bit_idx_d = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shreg_d = shift_w[WIDTH:1];
          if (bit_idx_q == LAST_IDX) begin
            state_d = S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      // Leaving at mid-stop lets a back-to-back start bit be caught.
      S_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          if (s) begin
            data_d  = shreg_q;
            dv_d    = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_BREAK: begin
        cnt_d = '0;
        if (rx_s) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign o_data      = data_q;
  assign o_dv        = dv_q;
  assign o_frame_err = ferr_q;
  assign o_busy      = (state_q != S_IDLE);

endmodule
